fp_mult_pipe: RTL and testbench
===============================

Name: fp_mult_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-754 floating-point multiplier with valid/ready backpressure, round-to-nearest-even, exception flags and an opaque tag carried alongside each operation.
- Next-generation multiplier for the accelerator datapath. Feeds the MAC/dot-product units.
- Accepts one operation per cycle whenever the output is not stalled.

Parameters:
- FRAC_WIDTH, 23, stored fraction bits (implicit 1 not stored)
- EXP_WIDTH, 8, exponent bits; BIAS = 2^(EXP_WIDTH-1)-1
- TAG_WIDTH, 4, width of sideband tag passed through unchanged (minimum 1)
- DATA_WIDTH (localparam), 1+EXP_WIDTH+FRAC_WIDTH

Ports:
- clkIn  in  1  clock
- rstIn  in  1  reset, asynchronous, active-high
- dataAIn  in  DATA_WIDTH  operand A
- dataBIn  in  DATA_WIDTH  operand B
- tagIn  in  TAG_WIDTH  sideband tag
- validIn  in  1  operands valid
- readyOut  out  1  block can accept operands this cycle
- dataOut  out  DATA_WIDTH  product
- tagOut  out  TAG_WIDTH  tag of the product
- flagsOut  out  4  {invalid, overflow, underflow, inexact}
- validOut  out  1  result valid
- readyIn  in  1  downstream accepts result

Behaviour:
- Reset (async, immediate): validOut, all internal stage valids, dataOut, tagOut and flagsOut = 0. In-flight operations are discarded.
- Advance: adv = !validOut || readyIn. readyOut = adv (combinational). When adv=0, all stages hold. An input transfer occurs when validIn && readyOut.
- Latency: exactly 3 cycles from transfer to validOut while adv stays 1. Throughput is 1 per cycle. Bubbles propagate as invalid stages.
- Output hold: dataOut, tagOut and flagsOut remain stable while validOut && !readyIn.
- S1, decode/multiply:
  - sign = sA^sB.
  - A subnormal input (exp=0) is treated as signed zero (DAZ), with no flag.
  - Classify zero, inf, NaN.
  - Full (FRAC_WIDTH+1)x(FRAC_WIDTH+1) mantissa product.
  - Signed exponent e = expA+expB-BIAS, width EXP_WIDTH+2.
- S2, normalise/round:
  - If product MSB = 1: shift right 1 and e+1.
  - Keep FRAC_WIDTH+1 bits. Guard = next bit. Sticky = OR of the remaining bits.
  - Round up when guard && (sticky || lsb).
  - Rounding carry-out: mantissa becomes 1.0 and e+1.
  - inexact = guard || sticky.
- S3, exceptions/pack. Priority order:
  1. Either NaN, or inf*zero: canonical qNaN {0, all-ones exp, 1, zeros}, invalid=1, other flags 0. An input sNaN also returns the canonical qNaN.
  2. Either inf: signed inf, flags 0.
  3. Either zero: signed zero, flags 0.
  4. e >= 2^EXP_WIDTH-1: signed inf, overflow=1, inexact=1.
  5. e <= 0 (after rounding): signed zero (FTZ), underflow=1, inexact=1.
  6. Otherwise: {sign, e[EXP_WIDTH-1:0], frac}, with inexact from S2.
- Tag: travels with its operation through all stages, and tagOut is registered with dataOut.
- Simultaneous input transfer and output drain in one cycle: both occur and the pipe shifts.
- rstIn asserted mid-stall: validOut drops immediately. After release, readyOut=1.

Test Plan:
- Basic: A=0x3FC00000, B=0x40000000, tag=5 -> 3 cycles later dataOut=0x40400000, tagOut=5, flags=0000.
- Rounding: 0x3F800001 x 0x3F800001 -> 0x3F800002, inexact=1. Tie-to-even: 0x3F800003 x 0x3FC00000 -> 0x3FC00004, inexact=1.
- Specials:
  - 0x7F800000 x 0x00000000 -> 0x7FC00000, invalid=1.
  - 0xFF800000 x 0x40000000 -> 0xFF800000, flags=0.
  - 0x7F800001 x 0x3F800000 -> 0x7FC00000, invalid=1.
- Overflow/underflow:
  - 0x7F000000 x 0x40000000 -> 0x7F800000, overflow+inexact.
  - 0x00800000 x 0x3F000000 -> 0x00000000, underflow+inexact.
  - 0x80800000 x 0x3F000000 -> 0x80000000, underflow+inexact.
- Backpressure: stream 8 ops back-to-back, readyIn=0 for cycles 4-7 -> readyOut=0 while validOut && !readyIn, no result lost or duplicated, results and tags in order, dataOut stable during the stall.
- Reset mid-stream: assert rstIn with 3 ops in flight -> validOut=0 and dataOut=0 immediately, no stale result after release. A new op yields its correct result 3 cycles after transfer.

Source files
------------

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage IEEE-754 multiplier (round-to-nearest-even, DAZ/FTZ)
// with valid/ready backpressure and a sideband tag that rides with each operation.
module fp_mult_pipe #(
    parameter int FRAC_WIDTH  = 23,
    parameter int EXP_WIDTH   = 8,
    parameter int TAG_WIDTH   = 4,
    localparam int DATA_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic [DATA_WIDTH-1:0] dataAIn,
    input  logic [DATA_WIDTH-1:0] dataBIn,
    input  logic [TAG_WIDTH-1:0]  tagIn,
    input  logic                  validIn,
    output logic                  readyOut,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic [TAG_WIDTH-1:0]  tagOut,
    output logic [3:0]            flagsOut,
    output logic                  validOut,
    input  logic                  readyIn
);
    localparam int MW = FRAC_WIDTH + 1;
    localparam int PW = 2 * MW;
    localparam int EW = EXP_WIDTH + 2;
    localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_WIDTH) - 1);
    localparam logic signed [EW-1:0] EZERO = '0;

    logic                  adv_s;
    logic [EXP_WIDTH-1:0]  exp_a_s, exp_b_s;
    logic [FRAC_WIDTH-1:0] frac_a_s, frac_b_s;
    logic                  a_zero_s, a_inf_s, a_nan_s, b_zero_s, b_inf_s, b_nan_s;

    logic                  s1_valid_d, s1_valid_q, s1_sign_d, s1_sign_q;
    logic                  s1_nan_d, s1_nan_q, s1_inf_d, s1_inf_q, s1_zero_d, s1_zero_q;
    logic [PW-1:0]         s1_prod_d, s1_prod_q;
    logic signed [EW-1:0]  s1_exp_d, s1_exp_q;
    logic [TAG_WIDTH-1:0]  s1_tag_d, s1_tag_q;

    logic [PW-1:0]         norm_s;
    logic [MW-1:0]         mant_s;
    logic [MW:0]           rnd_s;
    logic                  guard_s, sticky_s;

    logic                  s2_valid_d, s2_valid_q, s2_sign_d, s2_sign_q;
    logic                  s2_nan_d, s2_nan_q, s2_inf_d, s2_inf_q, s2_zero_d, s2_zero_q;
    logic [FRAC_WIDTH-1:0] s2_frac_d, s2_frac_q;
    logic signed [EW-1:0]  s2_exp_d, s2_exp_q;
    logic                  s2_inexact_d, s2_inexact_q;
    logic [TAG_WIDTH-1:0]  s2_tag_d, s2_tag_q;

    logic                  out_valid_d, out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_d, out_data_q;
    logic [TAG_WIDTH-1:0]  out_tag_d, out_tag_q;
    logic [3:0]            out_flags_d, out_flags_q;

    assign adv_s    = !out_valid_q || readyIn;
    assign readyOut = adv_s;
    assign validOut = out_valid_q;
    assign dataOut  = out_data_q;
    assign tagOut   = out_tag_q;
    assign flagsOut = out_flags_q;

    // S1: classify operands (subnormals count as zero), full mantissa product, biased exponent sum
    always_comb begin
        exp_a_s    = dataAIn[DATA_WIDTH-2 -: EXP_WIDTH];
        exp_b_s    = dataBIn[DATA_WIDTH-2 -: EXP_WIDTH];
        frac_a_s   = dataAIn[FRAC_WIDTH-1:0];
        frac_b_s   = dataBIn[FRAC_WIDTH-1:0];
        a_zero_s   = (exp_a_s == '0);
        b_zero_s   = (exp_b_s == '0);
        a_inf_s    = (exp_a_s == '1) && (frac_a_s == '0);
        b_inf_s    = (exp_b_s == '1) && (frac_b_s == '0);
        a_nan_s    = (exp_a_s == '1) && (frac_a_s != '0);
        b_nan_s    = (exp_b_s == '1) && (frac_b_s != '0);
        s1_valid_d = validIn;
        s1_sign_d  = dataAIn[DATA_WIDTH-1] ^ dataBIn[DATA_WIDTH-1];
        s1_nan_d   = a_nan_s | b_nan_s | (a_inf_s & b_zero_s) | (b_inf_s & a_zero_s);
        s1_inf_d   = a_inf_s | b_inf_s;
        s1_zero_d  = a_zero_s | b_zero_s;
        s1_prod_d  = PW'({1'b1, frac_a_s}) * PW'({1'b1, frac_b_s});
        s1_exp_d   = EW'(exp_a_s) + EW'(exp_b_s) - BIAS;
        s1_tag_d   = tagIn;
    end

    // S2: normalise to a leading one, then round to nearest even on guard/sticky
    always_comb begin
        norm_s       = s1_prod_q[PW-1] ? s1_prod_q : (s1_prod_q << 1);
        mant_s       = norm_s[PW-1 -: MW];
        guard_s      = norm_s[FRAC_WIDTH];
        sticky_s     = |norm_s[FRAC_WIDTH-1:0];
        rnd_s        = {1'b0, mant_s} + {{MW{1'b0}}, guard_s & (sticky_s | mant_s[0])};
        // A rounding carry leaves the low bits zero, so the fraction is already 1.0
        s2_frac_d    = rnd_s[FRAC_WIDTH-1:0];
        s2_exp_d     = s1_exp_q + EW'(s1_prod_q[PW-1]) + EW'(rnd_s[MW]);
        s2_inexact_d = guard_s | sticky_s;
        s2_valid_d   = s1_valid_q;
        s2_sign_d    = s1_sign_q;
        s2_nan_d     = s1_nan_q;
        s2_inf_d     = s1_inf_q;
        s2_zero_d    = s1_zero_q;
        s2_tag_d     = s1_tag_q;
    end

    // S3: resolve special cases in priority order and pack the result
    always_comb begin
        out_valid_d = s2_valid_q;
        out_tag_d   = s2_tag_q;
        if (s2_nan_q) begin
            out_data_d  = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(FRAC_WIDTH-1){1'b0}}};
            out_flags_d = 4'b1000;
        end else if (s2_inf_q) begin
            out_data_d  = {s2_sign_q, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
            out_flags_d = 4'b0000;
        end else if (s2_zero_q) begin
            out_data_d  = {s2_sign_q, {(DATA_WIDTH-1){1'b0}}};
            out_flags_d = 4'b0000;
        end else if (s2_exp_q >= EMAX) begin
            out_data_d  = {s2_sign_q, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
            out_flags_d = 4'b0101;
        end else if (s2_exp_q <= EZERO) begin
            out_data_d  = {s2_sign_q, {(DATA_WIDTH-1){1'b0}}};
            out_flags_d = 4'b0011;
        end else begin
            out_data_d  = {s2_sign_q, s2_exp_q[EXP_WIDTH-1:0], s2_frac_q};
            out_flags_d = {3'b000, s2_inexact_q};
        end
    end

    // Pipeline registers: every stage advances together or holds together
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_nan_q     <= 1'b0;
            s1_inf_q     <= 1'b0;
            s1_zero_q    <= 1'b0;
            s1_prod_q    <= '0;
            s1_exp_q     <= '0;
            s1_tag_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_sign_q    <= 1'b0;
            s2_nan_q     <= 1'b0;
            s2_inf_q     <= 1'b0;
            s2_zero_q    <= 1'b0;
            s2_frac_q    <= '0;
            s2_exp_q     <= '0;
            s2_inexact_q <= 1'b0;
            s2_tag_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_tag_q    <= '0;
            out_flags_q  <= 4'b0000;
        end else if (adv_s) begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_nan_q     <= s1_nan_d;
            s1_inf_q     <= s1_inf_d;
            s1_zero_q    <= s1_zero_d;
            s1_prod_q    <= s1_prod_d;
            s1_exp_q     <= s1_exp_d;
            s1_tag_q     <= s1_tag_d;
            s2_valid_q   <= s2_valid_d;
            s2_sign_q    <= s2_sign_d;
            s2_nan_q     <= s2_nan_d;
            s2_inf_q     <= s2_inf_d;
            s2_zero_q    <= s2_zero_d;
            s2_frac_q    <= s2_frac_d;
            s2_exp_q     <= s2_exp_d;
            s2_inexact_q <= s2_inexact_d;
            s2_tag_q     <= s2_tag_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_tag_q    <= out_tag_d;
            out_flags_q  <= out_flags_d;
        end
    end
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench for fp_mult_pipe (binary32 defaults): integer-arithmetic
// reference model, scoreboard queue, directed vectors, backpressure, reset and random traffic.
module tb_fp_mult_pipe;
    logic        clkIn = 1'b0;
    logic        rstIn;
    logic [31:0] dataAIn, dataBIn, dataOut;
    logic [3:0]  tagIn, tagOut, flagsOut;
    logic        validIn, readyOut, validOut, readyIn;

    always #5 clkIn = ~clkIn;

    fp_mult_pipe dut (
        .clkIn(clkIn), .rstIn(rstIn), .dataAIn(dataAIn), .dataBIn(dataBIn),
        .tagIn(tagIn), .validIn(validIn), .readyOut(readyOut), .dataOut(dataOut),
        .tagOut(tagOut), .flagsOut(flagsOut), .validOut(validOut), .readyIn(readyIn)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        logic [3:0]  flags;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0, errors = 0, cyc = 0, pops = 0;
    bit          lat_mode = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [3:0]  prev_tag, prev_flags;

    logic [31:0] va [9] = '{32'h3FC00000, 32'h3F800001, 32'h3F800003, 32'h7F800000, 32'hFF800000,
                            32'h7F800001, 32'h7F000000, 32'h00800000, 32'h80800000};
    logic [31:0] vb [9] = '{32'h40000000, 32'h3F800001, 32'h3FC00000, 32'h00000000, 32'h40000000,
                            32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F000000};
    logic [31:0] vr [9] = '{32'h40400000, 32'h3F800002, 32'h3FC00004, 32'h7FC00000, 32'hFF800000,
                            32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h80000000};
    logic [3:0]  vf [9] = '{4'b0000, 4'b0001, 4'b0001, 4'b1000, 4'b0000,
                            4'b1000, 4'b0101, 4'b0011, 4'b0011};

    always @(posedge clkIn) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Exact product as an integer, rounded by quotient/remainder against half an ulp
    function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] f);
        int      ea, eb, e, sh;
        longint  ma, mb, p, q, rem, half;
        bit      s, az, bz, ai, bi, an, bn;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == 255) && (a[22:0] == 23'h0);
        bi = (eb == 255) && (b[22:0] == 23'h0);
        an = (ea == 255) && (a[22:0] != 23'h0);
        bn = (eb == 255) && (b[22:0] != 23'h0);
        f  = 4'b0000;
        if (an || bn || (ai && bz) || (bi && az)) begin
            r = 32'h7FC00000;
            f = 4'b1000;
        end else if (ai || bi) begin
            r = {s, 8'hFF, 23'h0};
        end else if (az || bz) begin
            r = {s, 31'h0};
        end else begin
            ma   = 64'(a[22:0]) + 64'h80_0000;
            mb   = 64'(b[22:0]) + 64'h80_0000;
            p    = ma * mb;
            sh   = (p >= 64'h8000_0000_0000) ? 24 : 23;
            q    = p >> sh;
            rem  = p - (q << sh);
            half = longint'(1) << (sh - 1);
            e    = ea + eb - 127 + (sh - 23);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == 64'h100_0000) begin
                q = 64'h80_0000;
                e = e + 1;
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'h0};
                f = 4'b0101;
            end else if (e <= 0) begin
                r = {s, 31'h0};
                f = 4'b0011;
            end else begin
                r = {s, e[7:0], q[22:0]};
                f = {3'b000, rem != 0};
            end
        end
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v = $urandom;
        case ($urandom_range(0, 7))
            0: v[30:23] = 8'h00;
            1: v[30:23] = 8'hFF;
            2: v[22:0] = ($urandom_range(0, 1) != 0) ? 23'h000000 : 23'h7FFFFF;
            3, 4: v[30:23] = 8'($urandom_range(120, 134));
            default: v = v;
        endcase
        return v;
    endfunction

    // Scoreboard: checks handshake, output hold under stall, and each result in order
    always @(negedge clkIn) begin : mon
        exp_t        e;
        logic [31:0] r;
        logic [3:0]  f;
        if (rstIn) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("readyOut", 64'(readyOut), 64'(!validOut || readyIn));
            if (prev_stall) begin
                chk("hold_valid", 64'(validOut), 64'd1);
                chk("hold_data", 64'(dataOut), 64'(prev_data));
                chk("hold_tag", 64'(tagOut), 64'(prev_tag));
                chk("hold_flags", 64'(flagsOut), 64'(prev_flags));
            end
            if (validOut && readyIn) begin
                pops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0h required=none", dataOut);
                end else begin
                    e = exp_q.pop_front();
                    chk("dataOut", 64'(dataOut), 64'(e.data));
                    chk("tagOut", 64'(tagOut), 64'(e.tag));
                    chk("flagsOut", 64'(flagsOut), 64'(e.flags));
                    if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd3);
                end
            end
            if (validIn && readyOut) begin
                ref_mul(dataAIn, dataBIn, r, f);
                e.data  = r;
                e.tag   = tagIn;
                e.flags = f;
                e.cyc   = cyc;
                e.lat   = lat_mode;
                exp_q.push_back(e);
            end
            prev_stall = validOut && !readyIn;
            prev_data  = dataOut;
            prev_tag   = tagOut;
            prev_flags = flagsOut;
        end
    end

    // Present one operation and keep it up until it is accepted
    task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        int n = 0;
        dataAIn = a;
        dataBIn = b;
        tagIn   = t;
        validIn = 1'b1;
        @(negedge clkIn);
        while (!readyOut && n < 50) begin
            @(negedge clkIn);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=%0d required=<50", n);
        end
        @(posedge clkIn);
        #1 validIn = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  f;
        int          p0, sent;
        bit          acc;
        logic [31:0] bp_a [8];
        logic [31:0] bp_b [8];

        rstIn = 1'b1; validIn = 1'b0; readyIn = 1'b1;
        dataAIn = 32'h0; dataBIn = 32'h0; tagIn = 4'h0;
        repeat (2) @(posedge clkIn);
        #1;
        chk("rst_validOut", 64'(validOut), 64'd0);
        chk("rst_dataOut", 64'(dataOut), 64'd0);
        chk("rst_tagOut", 64'(tagOut), 64'd0);
        chk("rst_flagsOut", 64'(flagsOut), 64'd0);
        chk("rst_readyOut", 64'(readyOut), 64'd1);
        rstIn = 1'b0;

        for (int i = 0; i < 9; i++) begin
            ref_mul(va[i], vb[i], r, f);
            chk($sformatf("model_data_%0d", i), 64'(r), 64'(vr[i]));
            chk($sformatf("model_flags_%0d", i), 64'(f), 64'(vf[i]));
        end

        // Directed vectors back-to-back with an always-ready sink
        @(posedge clkIn);
        #1 lat_mode = 1'b1;
        for (int i = 0; i < 9; i++) drive_op(va[i], vb[i], 4'(i + 5));
        repeat (6) @(posedge clkIn);
        #1 chk("directed_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure: 8 ops streamed, sink stalls on cycles 4..7
        lat_mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bp_a[i] = rand_op();
            bp_b[i] = rand_op();
        end
        p0 = pops;
        sent = 0;
        for (int c = 0; c < 24; c++) begin
            readyIn = !(c >= 4 && c <= 7);
            validIn = (sent < 8);
            if (sent < 8) begin
                dataAIn = bp_a[sent];
                dataBIn = bp_b[sent];
                tagIn   = 4'(sent);
            end
            @(negedge clkIn);
            acc = validIn && readyOut;
            @(posedge clkIn);
            #1 if (acc) sent++;
        end
        validIn = 1'b0;
        readyIn = 1'b1;
        chk("bp_results", 64'(pops - p0), 64'd8);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) drive_op(rand_op(), rand_op(), 4'(i));
        chk("pre_reset_valid", 64'(validOut), 64'd1);
        #1 rstIn = 1'b1;
        #1;
        chk("midrst_validOut", 64'(validOut), 64'd0);
        chk("midrst_dataOut", 64'(dataOut), 64'd0);
        chk("midrst_readyOut", 64'(readyOut), 64'd1);
        repeat (2) @(posedge clkIn);
        #1 rstIn = 1'b0;
        p0 = pops;
        repeat (6) @(posedge clkIn);
        #1 chk("no_stale_after_reset", 64'(pops - p0), 64'd0);
        lat_mode = 1'b1;
        drive_op(32'h3FC00000, 32'h40000000, 4'd9);
        repeat (5) @(posedge clkIn);
        #1 chk("post_reset_result", 64'(pops - p0), 64'd1);
        lat_mode = 1'b0;

        // Random traffic with random stalls
        for (int c = 0; c < 400; c++) begin
            validIn = ($urandom_range(0, 3) != 0);
            readyIn = ($urandom_range(0, 9) < 7);
            dataAIn = rand_op();
            dataBIn = rand_op();
            tagIn   = 4'($urandom);
            @(posedge clkIn);
            #1;
        end
        validIn = 1'b0;
        readyIn = 1'b1;
        repeat (8) @(posedge clkIn);
        #1 chk("final_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
